life_alarm: RTL and testbench

Hazard alarm controller downstream of the life-support saturation counter. It consumes the registered shield, temperature, power and O2 telemetry and the `fatal` flag, debounces each hazard condition, and runs a four-level alert state machine. The state machine drives a crew siren with an acknowledge handshake, latches sticky cause flags and counts escalations for the command display.

---
 rtl/life_alarm.sv | 132 +++++++++++++
 tb/tb_life_alarm.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/life_alarm.sv
// Hazard alarm controller: debounces four telemetry hazards and runs a four-level
// alert state machine with siren acknowledge, sticky cause flags and escalation count.
module life_alarm #(
    parameter int N          = 8,
    parameter int TEMP_LIMIT = 100,
    parameter int O2_LOW     = 4,
    parameter int PWR_LOW    = 16,
    parameter int SHIELD_LOW = 20,
    parameter int HOLD       = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] shield,
    input  logic [N-1:0] temp,
    input  logic [N-1:0] power,
    input  logic [N-1:0] o2,
    input  logic         fatal,
    input  logic         ack,
    output logic [1:0]   level,
    output logic [3:0]   flags,
    output logic         siren,
    output logic         abandon,
    output logic [7:0]   events
);

    typedef enum logic [1:0] {
        NOMINAL = 2'b00,
        CAUTION = 2'b01,
        WARNING = 2'b10,
        ABANDON = 2'b11
    } state_t;

    localparam logic [N-1:0] TEMP_LIM_C   = N'(TEMP_LIMIT);
    localparam logic [N-1:0] O2_LOW_C     = N'(O2_LOW);
    localparam logic [N-1:0] PWR_LOW_C    = N'(PWR_LOW);
    localparam logic [N-1:0] SHIELD_LOW_C = N'(SHIELD_LOW);
    localparam logic [3:0]   HOLD_C       = 4'(HOLD);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt [4];
    logic [3:0]  r_flags;
    logic        r_ack_l;
    logic        r_siren;
    logic        r_abandon;
    logic [7:0]  r_events;
    logic [3:0]  w_cond;
    logic [3:0]  w_qual;
    logic [2:0]  w_q_cnt;
    logic        w_ack_l_next;

    // Raw hazard conditions and qualification from the registered debounce counters.
    always_comb begin
        w_cond[3] = (temp >= TEMP_LIM_C);
        w_cond[2] = (o2 <= O2_LOW_C);
        w_cond[1] = (power <= PWR_LOW_C);
        w_cond[0] = (shield <= SHIELD_LOW_C);
        for (int i = 0; i < 4; i++) begin
            w_qual[i] = (r_cnt[i] == HOLD_C);
        end
        w_q_cnt = {2'b00, w_qual[0]} + {2'b00, w_qual[1]}
                + {2'b00, w_qual[2]} + {2'b00, w_qual[3]};
    end

    // Alert level transitions; fatal pre-empts everything except the terminal state.
    always_comb begin
        w_next = r_state;
        if (fatal && (r_state != ABANDON)) begin
            w_next = ABANDON;
        end else begin
            case (r_state)
                NOMINAL: begin
                    if (w_q_cnt >= 3'd2)      w_next = WARNING;
                    else if (w_q_cnt == 3'd1) w_next = CAUTION;
                    else                      w_next = NOMINAL;
                end
                CAUTION: begin
                    if (w_q_cnt >= 3'd2)      w_next = WARNING;
                    else if (w_q_cnt == 3'd0) w_next = NOMINAL;
                    else                      w_next = CAUTION;
                end
                WARNING: begin
                    if ((w_q_cnt <= 3'd1) && (r_ack_l || ack))
                        w_next = (w_q_cnt == 3'd1) ? CAUTION : NOMINAL;
                    else
                        w_next = WARNING;
                end
                ABANDON: w_next = ABANDON;
                default: w_next = NOMINAL;
            endcase
        end
        // The latch only survives while WARNING is both current and next.
        if ((w_next == WARNING) && (r_state == WARNING)) begin
            w_ack_l_next = r_ack_l | ack;
        end else begin
            w_ack_l_next = 1'b0;
        end
    end

    // All state: debounce counters, FSM, ack latch, flags, siren and event counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) r_cnt[i] <= 4'd0;
            r_state   <= NOMINAL;
            r_flags   <= 4'b0000;
            r_ack_l   <= 1'b0;
            r_siren   <= 1'b0;
            r_abandon <= 1'b0;
            r_events  <= 8'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!w_cond[i])              r_cnt[i] <= 4'd0;
                else if (r_cnt[i] != HOLD_C) r_cnt[i] <= r_cnt[i] + 4'd1;
                else                         r_cnt[i] <= r_cnt[i];
            end
            r_state   <= w_next;
            r_ack_l   <= w_ack_l_next;
            r_flags   <= w_qual | (ack ? 4'b0000 : r_flags);
            r_siren   <= ((w_next == WARNING) && !w_ack_l_next) || (w_next == ABANDON);
            r_abandon <= (w_next == ABANDON);
            if ((w_next > r_state) && (r_events != 8'hFF)) r_events <= r_events + 8'd1;
            else                                           r_events <= r_events;
        end
    end

    assign level   = r_state;
    assign flags   = r_flags;
    assign siren   = r_siren;
    assign abandon = r_abandon;
    assign events  = r_events;

endmodule

// File: tb/tb_life_alarm.sv
// Scoreboard bench for life_alarm: a behavioural model predicts each cycle's outputs,
// a monitor compares them; directed scenarios plus randomized telemetry.
module tb_life_alarm;
    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] shield = 8'd68, temp = 8'd50, power = 8'd127, o2 = 8'd8;
    logic       fatal = 1'b0, ack = 1'b0;
    logic [1:0] level;
    logic [3:0] flags;
    logic       siren, abandon;
    logic [7:0] events;

    always #5 clk = ~clk;

    life_alarm #(.N(8), .TEMP_LIMIT(100), .O2_LOW(4), .PWR_LOW(16), .SHIELD_LOW(20),
                 .HOLD(HOLD)) dut (
        .clk(clk), .rst(rst), .shield(shield), .temp(temp), .power(power), .o2(o2),
        .fatal(fatal), .ack(ack), .level(level), .flags(flags), .siren(siren),
        .abandon(abandon), .events(events));

    typedef struct packed {
        logic [1:0] level;
        logic [3:0] flags;
        logic       siren;
        logic       abandon;
        logic [7:0] events;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference state: run length of each hazard, level as an integer, etc.
    int   m_run[4];
    int   m_level = 0;
    int   m_events = 0;
    bit   m_ackl = 0;
    bit   m_flags[4];

    function automatic void model_edge();
        bit cond[4];
        bit qual[4];
        int qn, nl;
        exp_t e;
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin m_run[i] = 0; m_flags[i] = 0; end
            m_level = 0; m_events = 0; m_ackl = 0;
        end else begin
            cond[3] = (temp >= 100); cond[2] = (o2 <= 4);
            cond[1] = (power <= 16); cond[0] = (shield <= 20);
            qn = 0;
            for (int i = 0; i < 4; i++) begin
                qual[i] = (m_run[i] >= HOLD);
                if (qual[i]) qn++;
            end
            if (fatal && m_level != 3) nl = 3;
            else if (m_level == 3) nl = 3;
            else if (m_level == 2) nl = (qn <= 1 && (m_ackl || ack)) ? qn : 2;
            else nl = (qn >= 2) ? 2 : qn;
            m_ackl = (m_level == 2 && nl == 2) ? (m_ackl | ack) : 1'b0;
            if (nl > m_level && m_events < 255) m_events++;
            m_level = nl;
            for (int i = 0; i < 4; i++) begin
                if (qual[i]) m_flags[i] = 1;
                else if (ack) m_flags[i] = 0;
                m_run[i] = cond[i] ? ((m_run[i] < 100) ? m_run[i] + 1 : 100) : 0;
            end
        end
        e.level   = 2'(m_level);
        e.flags   = {m_flags[3], m_flags[2], m_flags[1], m_flags[0]};
        e.siren   = (m_level == 3) || (m_level == 2 && !m_ackl);
        e.abandon = (m_level == 3);
        e.events  = 8'(m_events);
        sb_q.push_back(e);
    endfunction

    // One clock: inputs already stable, predict at the edge, return at the next falling edge.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic safe();
        temp = 8'd50; o2 = 8'd8; power = 8'd127; shield = 8'd68;
    endtask

    // Monitor: every cycle is an output beat; compare against the oldest prediction.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            vectors++;
            if ({level, flags, siren, abandon, events} !== e) begin
                miscompares++;
                $display("FAIL scoreboard t=%0t: got lvl=%0d flg=%b sir=%b ab=%b ev=%0d, expected lvl=%0d flg=%b sir=%b ab=%b ev=%0d",
                         $time, level, flags, siren, abandon, events,
                         e.level, e.flags, e.siren, e.abandon, e.events);
            end
        end
    end

    initial begin
        @(negedge clk);
        rst = 1'b0; tick(2);
        chk("reset_level", level, 0); chk("reset_events", events, 0);
        rst = 1'b1;

        safe(); tick(20);
        chk("base_level", level, 0); chk("base_flags", flags, 0);
        chk("base_siren", siren, 0); chk("base_events", events, 0);

        temp = 8'd100; tick(3); temp = 8'd99; tick(1);
        chk("debounce_level", level, 0);
        temp = 8'd100; tick(4);
        chk("hold_minus1_level", level, 0);
        tick(1);
        chk("caution_level", level, 1); chk("caution_flags", flags, 4'b1000);
        chk("caution_events", events, 1);
        safe(); tick(2);
        chk("recover_level", level, 0); chk("sticky_flags", flags, 4'b1000);
        ack = 1'b1; tick(1); ack = 1'b0;
        chk("ack_clear_flags", flags, 0);

        rst = 1'b0; tick(1); rst = 1'b1;
        temp = 8'd100; o2 = 8'd3; tick(5);
        chk("warn_level", level, 2); chk("warn_siren", siren, 1); chk("warn_events", events, 1);
        ack = 1'b1; tick(1); ack = 1'b0;
        chk("ack_siren", siren, 0); chk("ack_level", level, 2);
        safe(); tick(2);
        chk("warn_recover", level, 0);
        ack = 1'b1; tick(1); ack = 1'b0;
        chk("warn_flags_clear", flags, 0);

        temp = 8'd100; o2 = 8'd3; tick(5);
        safe(); tick(12);
        chk("unack_level", level, 2); chk("unack_siren", siren, 1);
        ack = 1'b1; tick(1); ack = 1'b0;
        chk("unack_ack_level", level, 0); chk("unack_ack_siren", siren, 0);

        temp = 8'd100; tick(5);
        chk("pre_fatal_level", level, 1);
        fatal = 1'b1; tick(1); fatal = 1'b0;
        chk("fatal_level", level, 3); chk("fatal_abandon", abandon, 1);
        chk("fatal_siren", siren, 1); chk("fatal_events", events, 4);
        for (int k = 0; k < 3; k++) begin ack = 1'b1; tick(1); ack = 1'b0; tick(1); end
        chk("abandon_sticky", level, 3);
        rst = 1'b0; tick(1); rst = 1'b1;
        chk("abandon_reset", {level, flags, siren, abandon, events}, 0);

        rst = 1'b0; fatal = 1'b1; tick(1); rst = 1'b1; fatal = 1'b0;
        chk("rst_vs_fatal_level", level, 0); chk("rst_vs_fatal_abandon", abandon, 0);

        safe();
        for (int k = 0; k < 260; k++) begin
            temp = 8'd100; tick(HOLD + 1);
            temp = 8'd50; tick(2);
        end
        chk("events_saturate", events, 255);

        rst = 1'b0; tick(1); rst = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) temp   = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(99, 101)) : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) o2     = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(3, 5))    : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) power  = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(15, 17))  : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) shield = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(19, 21))  : 8'($urandom_range(0, 255));
            ack   = ($urandom_range(0, 5) == 0);
            fatal = ($urandom_range(0, 299) == 0);
            rst   = ($urandom_range(0, 249) != 0);
            tick(1);
        end
        rst = 1'b1; fatal = 1'b0; ack = 1'b0;

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
